// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - requester/FIFO write-side bundle for fifo_write_arbiter
interface fifo_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    localparam int OW = $clog2(N_REQ);

    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        gnt;
    logic                    fifo_full;
    logic                    fifo_wn;
    logic [DATA_W-1:0]       fifo_din;
    logic [OW-1:0]           owner;
    logic                    busy;

    modport master (
        output req, req_data, fifo_full,
        input  gnt, fifo_wn, fifo_din, owner, busy
    );

    modport slave (
        input  req, req_data, fifo_full,
        output gnt, fifo_wn, fifo_din, owner, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    fifo_write_arbiter_if.slave   bus
);
    localparam int OW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [OW-1:0]   winner;
    logic [OW-1:0]   idx;
    logic            beat;
    logic            last_beat;

    // Descending scan so the requester closest to rr_ptr is assigned last and wins.
    always_comb begin
        winner = rr_ptr_q;
        idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = rr_ptr_q + OW'(i);
            if (bus.req[idx]) winner = idx;
        end
    end

    assign beat      = (state_q == BURST) && bus.req[owner_q] && !bus.fifo_full;
    assign last_beat = beat && (beat_cnt_q == CW'(MAX_BURST - 1));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d    = BURST;
                    owner_d    = winner;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (!bus.req[owner_q] || last_beat) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_q + OW'(1);
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Write side is combinational so a full FIFO blocks the write in the same cycle.
    assign bus.fifo_wn  = beat;
    assign bus.fifo_din = beat ? bus.req_data[owner_q*DATA_W +: DATA_W] : '0;
    assign bus.gnt      = beat ? (N_REQ'(1) << owner_q) : '0;
    assign bus.owner    = owner_q;
    assign bus.busy     = (state_q == BURST);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed self-checking bench for fifo_write_arbiter
module tb_fifo_write_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fifo_write_arbiter_if #(.N_REQ(4), .DATA_W(32)) bus ();

    fifo_write_arbiter #(.N_REQ(4), .DATA_W(32), .MAX_BURST(4)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        reset         = 1'b0;
        bus.req       = 4'b0000;
        bus.fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        bus.req       = 4'b1111;
        bus.fifo_full = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({bus.fifo_wn, bus.gnt, bus.busy, bus.owner, bus.fifo_din} !== 40'd0) begin
                errors++;
                $display("FAIL reset_hold c=%0d: wn=%b gnt=%b busy=%b owner=%0d din=%h, want all zero",
                         c, bus.fifo_wn, bus.gnt, bus.busy, bus.owner, bus.fifo_din);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.fifo_wn, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset_arb_cycle: wn=%b busy=%b, want 0 0", bus.fifo_wn, bus.busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.fifo_wn, bus.gnt, bus.owner, bus.busy} !== {1'b1, 4'b0001, 2'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_first_grant: wn=%b gnt=%b owner=%0d busy=%b, want 1 0001 0 1",
                     bus.fifo_wn, bus.gnt, bus.owner, bus.busy);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0100;
        for (int r = 0; r < 2; r++) begin
            #1;
            checks++;
            if ({bus.fifo_wn, bus.gnt, bus.fifo_din} !== 37'd0) begin
                errors++;
                $display("FAIL single_idle r=%0d: wn=%b gnt=%b din=%h, want 0 0000 0",
                         r, bus.fifo_wn, bus.gnt, bus.fifo_din);
            end
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                #1;
                checks++;
                if ({bus.fifo_wn, bus.gnt, bus.owner, bus.fifo_din} !== {1'b1, 4'b0100, 2'd2, 32'hA5A5_0002}) begin
                    errors++;
                    $display("FAIL single_beat r=%0d k=%0d: wn=%b gnt=%b owner=%0d din=%h, want 1 0100 2 a5a50002",
                             r, k, bus.fifo_wn, bus.gnt, bus.owner, bus.fifo_din);
                end
                @(negedge clk);
            end
        end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_rotation();
        logic [1:0]  exp_own;
        logic [3:0]  exp_gnt;
        logic [31:0] exp_din;
        do_reset();
        bus.req = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            exp_own = 2'(b % 4);
            exp_gnt = 4'b0001 << exp_own;
            exp_din = 32'hA5A5_0000 + 32'(exp_own);
            #1;
            checks++;
            if ({bus.fifo_wn, bus.busy, bus.gnt} !== 6'd0) begin
                errors++;
                $display("FAIL rot_idle b=%0d: wn=%b busy=%b gnt=%b, want 0 0 0000",
                         b, bus.fifo_wn, bus.busy, bus.gnt);
            end
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                #1;
                checks++;
                if ({bus.fifo_wn, bus.gnt, bus.owner, bus.fifo_din} !== {1'b1, exp_gnt, exp_own, exp_din}) begin
                    errors++;
                    $display("FAIL rot_beat b=%0d k=%0d: wn=%b gnt=%b owner=%0d din=%h, want 1 %b %0d %h",
                             b, k, bus.fifo_wn, bus.gnt, bus.owner, bus.fifo_din, exp_gnt, exp_own, exp_din);
                end
                @(negedge clk);
            end
        end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_full_stall();
        do_reset();
        bus.req = 4'b0010;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({bus.fifo_wn, bus.gnt, bus.fifo_din} !== {1'b1, 4'b0010, 32'hA5A5_0001}) begin
                errors++;
                $display("FAIL stall_pre k=%0d: wn=%b gnt=%b din=%h, want 1 0010 a5a50001",
                         k, bus.fifo_wn, bus.gnt, bus.fifo_din);
            end
            @(negedge clk);
        end
        bus.fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if ({bus.fifo_wn, bus.gnt, bus.fifo_din, bus.busy} !== {1'b0, 4'b0000, 32'd0, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold s=%0d: wn=%b gnt=%b din=%h busy=%b, want 0 0000 0 1",
                         s, bus.fifo_wn, bus.gnt, bus.fifo_din, bus.busy);
            end
            @(negedge clk);
        end
        bus.fifo_full = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if ({bus.fifo_wn, bus.gnt, bus.fifo_din} !== {1'b1, 4'b0010, 32'hA5A5_0001}) begin
                errors++;
                $display("FAIL stall_post k=%0d: wn=%b gnt=%b din=%h, want 1 0010 a5a50001",
                         k, bus.fifo_wn, bus.gnt, bus.fifo_din);
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({bus.fifo_wn, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL stall_end: wn=%b busy=%b, want 0 0", bus.fifo_wn, bus.busy);
        end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_early_drop();
        do_reset();
        bus.req = 4'b1000;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.fifo_wn, bus.gnt, bus.owner} !== {1'b1, 4'b1000, 2'd3}) begin
            errors++;
            $display("FAIL drop_beat: wn=%b gnt=%b owner=%0d, want 1 1000 3", bus.fifo_wn, bus.gnt, bus.owner);
        end
        @(negedge clk);
        bus.req = 4'b0000;
        #1;
        checks++;
        if ({bus.fifo_wn, bus.gnt, bus.busy} !== {1'b0, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL drop_cycle: wn=%b gnt=%b busy=%b, want 0 0000 1", bus.fifo_wn, bus.gnt, bus.busy);
        end
        @(negedge clk);
        bus.req = 4'b1001;
        #1;
        checks++;
        if ({bus.fifo_wn, bus.busy} !== 2'b00) begin
            errors++;
            $display("FAIL drop_idle: wn=%b busy=%b, want 0 0", bus.fifo_wn, bus.busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.fifo_wn, bus.gnt, bus.owner} !== {1'b1, 4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL drop_next_winner: wn=%b gnt=%b owner=%0d, want 1 0001 0",
                     bus.fifo_wn, bus.gnt, bus.owner);
        end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.req = 4'b0100;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if ({bus.fifo_wn, bus.gnt} !== {1'b1, 4'b0100}) begin
            errors++;
            $display("FAIL rmid_beat1: wn=%b gnt=%b, want 1 0100", bus.fifo_wn, bus.gnt);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.fifo_wn, bus.gnt, bus.owner} !== {1'b1, 4'b0100, 2'd2}) begin
            errors++;
            $display("FAIL rmid_beat2: wn=%b gnt=%b owner=%0d, want 1 0100 2", bus.fifo_wn, bus.gnt, bus.owner);
        end
        @(negedge clk);
        reset   = 1'b1;
        bus.req = 4'b1111;
        #1;
        checks++;
        if ({bus.busy, bus.fifo_wn, bus.gnt, bus.owner} !== 8'd0) begin
            errors++;
            $display("FAIL rmid_after: busy=%b wn=%b gnt=%b owner=%0d, want 0 0 0000 0",
                     bus.busy, bus.fifo_wn, bus.gnt, bus.owner);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.fifo_wn, bus.gnt, bus.owner} !== {1'b1, 4'b0001, 2'd0}) begin
            errors++;
            $display("FAIL rmid_rr_ptr: wn=%b gnt=%b owner=%0d, want 1 0001 0", bus.fifo_wn, bus.gnt, bus.owner);
        end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        bus.req       = 4'b0000;
        bus.req_data  = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
        bus.fifo_full = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_rotation();
        test_full_stall();
        test_early_drop();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
